si_echo_buffer: RTL

SI_ECHO_BUFFER -- requirements
Module: si_echo_buffer

---
 rtl/si_echo_buffer_pkg.sv | 13 +
 rtl/si_fifo.sv | 97 +++++++++
 rtl/si_echo_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/si_echo_buffer_pkg.sv
// Shared SI package: mode encodings used by the echo buffer and its bench.
//   MODE_ECHO   - store byte unchanged
//   MODE_INVERT - store bitwise NOT of byte
//   MODE_INCR   - store byte + 1 (wrapping)
//   MODE_DROP   - consume and count byte, do not store it
package si_echo_buffer_pkg;

  localparam logic [1:0] MODE_ECHO   = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_INCR   = 2'b10;
  localparam logic [1:0] MODE_DROP   = 2'b11;

endpackage

// File: rtl/si_fifo.sv
// si_fifo: circular buffer storage with head/tail pointers and an entry count.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   push, wdata     - write wdata at tail (ignored when full or flushing)
//   pop             - advance head (ignored when empty or flushing)
//   flush           - synchronous clear of head, tail and level
//   rdata           - entry at head, combinational from storage
//   level           - current entry count (0..DEPTH)
//   full, empty     - level == DEPTH, level == 0
module si_fifo
  import si_echo_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == {LW{1'b0}});
  assign level = level_q;
  assign rdata = mem_q[head_q];

  // Qualified strobes: a flush overrides both sides.
  assign push_ok = push & ~full  & ~flush;
  assign pop_ok  = pop  & ~empty & ~flush;

  // Next-state for pointers and count; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (flush) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      level_d = {LW{1'b0}};
    end else begin
      if (push_ok) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_ok) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      level_q <= {LW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q] <= wdata;
    end
  end

endmodule

// File: rtl/si_echo_buffer.sv
// si_echo_buffer: accepts SI bytes, transforms them per mode, buffers them
// and replays them downstream; tracks accepted-byte count and last raw byte.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   rx_data_si/rx_rdy_si/rx_ack_si - upstream handshake (ack combinational)
//   tx_data_si/tx_rdy_si/tx_ack_si - downstream handshake (head of buffer)
//   mode                           - 00 echo, 01 invert, 10 increment, 11 drop
//   flush                          - synchronous buffer clear
//   level                          - buffered entry count
//   rx_count                       - accepted-byte counter (wraps)
//   last_byte                      - last accepted raw byte
module si_echo_buffer
  import si_echo_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       rx_data_si,
  input  logic                   rx_rdy_si,
  output logic                   rx_ack_si,
  output logic [WIDTH-1:0]       tx_data_si,
  output logic                   tx_rdy_si,
  input  logic                   tx_ack_si,
  input  logic [1:0]             mode,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            rx_count,
  output logic [WIDTH-1:0]       last_byte
);

  localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);

  logic             full, empty;
  logic             push, pop;
  logic [WIDTH-1:0] wdata;
  logic [15:0]      rx_count_q, rx_count_d;
  logic [WIDTH-1:0] last_byte_q, last_byte_d;

  // Drop mode never stores, so a full buffer does not back-pressure it.
  // Gating with rst keeps ack low throughout reset.
  always_comb begin
    rx_ack_si = 1'b0;
    if (mode == MODE_DROP) begin
      rx_ack_si = rst & rx_rdy_si & ~flush;
    end else begin
      rx_ack_si = rst & rx_rdy_si & ~flush & ~full;
    end
  end

  assign push      = rx_ack_si & (mode != MODE_DROP);
  assign pop       = tx_ack_si & tx_rdy_si;
  assign tx_rdy_si = ~empty;

  // Transform is applied at write time so stored bytes keep their mode.
  always_comb begin
    case (mode)
      MODE_ECHO:   wdata = rx_data_si;
      MODE_INVERT: wdata = ~rx_data_si;
      MODE_INCR:   wdata = rx_data_si + DATA_ONE;
      default:     wdata = rx_data_si;
    endcase
  end

  // Counter and last-byte next state; both ignore flush.
  always_comb begin
    rx_count_d  = rx_count_q;
    last_byte_d = last_byte_q;
    if (rx_ack_si) begin
      rx_count_d  = rx_count_q + 16'd1;
      last_byte_d = rx_data_si;
    end else begin
      rx_count_d  = rx_count_q;
      last_byte_d = last_byte_q;
    end
  end

  // Counter and last-byte registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_count_q  <= 16'd0;
      last_byte_q <= {WIDTH{1'b0}};
    end else begin
      rx_count_q  <= rx_count_d;
      last_byte_q <= last_byte_d;
    end
  end

  assign rx_count  = rx_count_q;
  assign last_byte = last_byte_q;

  si_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (tx_data_si),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule
